wash_cycle_timer: RTL and testbench
===================================

Name: wash_cycle_timer

Overview:
Per-phase duration timer for the washer controller. It produces the phase-done flags Tf, Tw, Td, Tr and Ts that the washer state machine consumes. It also consumes that machine's one-cycle R restart pulse and its current phase code. On each restart it loads the duration for the phase being entered, counts prescaled ticks with pause support for the door hold, and raises exactly one done flag.

Parameters:
TICK_DIV, 50000000, clk cycles per timer tick (≥2)
CNT_W, 8, width of duration counter / remaining
FILL_T, 30, ticks for fill phases (1,4)
WASH_T, 120, ticks for wash (2)
DRAIN_T, 20, ticks for drain phases (3,6)
RINSE_T, 60, ticks for rinse (5)
SPIN_T, 90, ticks for spin (7)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
R  in  1  restart pulse from washer FSM; sampled on posedge clk
phase  in  3  current washer phase: 0 idle, 1 fill_1, 2 wash, 3 drain_1, 4 fill_2, 5 rinse, 6 drain_2, 7 spin
hold  in  1  pause request; door open
quick  in  1  quick-cycle select; sampled in ARM only
Tf  out  1  fill done
Tw  out  1  wash done
Td  out  1  drain done
Tr  out  1  rinse done
Ts  out  1  spin done
busy  out  1  high in ARM/RUN/PAUSE
remaining  out  CNT_W  ticks left in current phase

Behaviour:
- Reset (reset=0, async): state=IDLE; remaining=0, prescaler=0, latched phase=0. All T outputs and busy are 0.
- All outputs are registered. busy is decoded from the state register.
- R=1 at any edge, in any state, is the highest priority, above hold. It clears all T outputs, remaining and the prescaler, and sets state=ARM.
- ARM (one cycle): latch phase. The FSM has updated phase by this cycle.
  - phase=0: go to IDLE, nothing loaded.
  - Otherwise load remaining with that phase's duration.
  - If quick=1, WASH_T, RINSE_T and SPIN_T are shifted right by 1, with a minimum of 1.
  - Loaded value 0: go to DONE directly. Nonzero: go to RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. The tick is the cycle where the count equals TICK_DIV-1; the count then wraps to 0.
  - Each tick decrements remaining.
  - A tick with remaining=1 sets remaining=0 and state=DONE.
  - hold=1 in RUN: go to PAUSE. The prescaler and remaining freeze; no tick occurs that cycle.
- PAUSE: hold=0 resumes RUN from the frozen prescaler value. No loss or gain of count.
- DONE:
  - Assert one T flag, chosen by latched phase: 1,4→Tf; 2→Tw; 3,6→Td; 5→Tr; 7→Ts.
  - The flag is a level, held until the next R.
  - hold is ignored in DONE and IDLE.
- Done-to-flag latency: the flag is high on the edge after the final tick.
- Total phase latency from R: 1 (ARM) + D·TICK_DIV + 1 cycles to the flag.
- R in the same cycle as a final tick: R wins. No flag is raised and the new phase loads.
- Reset mid-run aborts immediately. The next run needs a fresh R.
- Counter arithmetic is unsigned CNT_W bits. Durations wider than CNT_W are an elaboration error, checked by a generate-time assertion.

Decomposition:
- Package washer_pkg:
  - phase code constants PH_IDLE..PH_SPIN, matching the washer FSM state encoding;
  - timer state encoding: IDLE, ARM, RUN, PAUSE, DONE;
  - the phase→flag mapping function;
  - the phase→duration lookup with quick halving.
- One sub-module, tick_prescaler:
  - ports: clk, reset, clr, en, tick;
  - width $clog2(TICK_DIV).

Test Plan:
All tests use TICK_DIV=4 and FILL_T=3, WASH_T=6, DRAIN_T=2, RINSE_T=4, SPIN_T=5.
- Reset: hold reset low, then release → all outputs 0, busy=0. Random hold toggles leave outputs at 0.
- Basic fill: R pulse, then phase=1 → busy next cycle, remaining=3. Tf rises exactly 14 cycles after R (1+3·4+1). Tf stays high until the next R, which clears it.
- Full sequence: drive phases 1..7, each started by R when the prior flag rises → flags in order Tf,Tw,Td,Tf,Tr,Td,Ts. Only one flag is high at a time.
- Pause: wash with hold=1 for 10 cycles mid-count → Tw delayed by exactly 10 cycles. remaining is frozen during the pause.
- Quick: quick=1 at ARM for spin → remaining loads 2 and Ts arrives after 10 cycles. Toggling quick mid-RUN has no effect.
- Boundaries:
  - R coincident with the final tick → no flag, remaining reloads.
  - R then phase=0 → IDLE, busy=0.
  - reset asserted during RUN → all outputs 0 immediately (async).

Source files
------------

// File: rtl/washer_pkg.sv
// Shared washer definitions: phase codes, timer states,
// phase-to-flag mapping and phase-to-duration lookup.
package washer_pkg;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_FILL_1  = 3'd1;
    localparam logic [2:0] PH_WASH    = 3'd2;
    localparam logic [2:0] PH_DRAIN_1 = 3'd3;
    localparam logic [2:0] PH_FILL_2  = 3'd4;
    localparam logic [2:0] PH_RINSE   = 3'd5;
    localparam logic [2:0] PH_DRAIN_2 = 3'd6;
    localparam logic [2:0] PH_SPIN    = 3'd7;

    typedef enum logic [2:0] {
        T_IDLE,
        T_ARM,
        T_RUN,
        T_PAUSE,
        T_DONE
    } tstate_t;

    typedef struct packed {
        logic ts;
        logic tr;
        logic td;
        logic tw;
        logic tf;
    } tflags_t;

    function automatic tflags_t phase_flags(
        input logic [2:0] ph
    );
        tflags_t f;
        f = '0;
        unique case (1'b1)
            (ph == PH_FILL_1),
            (ph == PH_FILL_2):  f.tf = 1'b1;
            (ph == PH_WASH):    f.tw = 1'b1;
            (ph == PH_DRAIN_1),
            (ph == PH_DRAIN_2): f.td = 1'b1;
            (ph == PH_RINSE):   f.tr = 1'b1;
            (ph == PH_SPIN):    f.ts = 1'b1;
            default:            f = '0;
        endcase
        return f;
    endfunction

    // Quick cycle halves the long phases but never drops to zero.
    function automatic int unsigned quick_dur(
        input int unsigned d,
        input logic        q
    );
        int unsigned h;
        h = d >> 1;
        if (!q) return d;
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

    function automatic int unsigned phase_duration(
        input logic [2:0]  ph,
        input logic        q,
        input int unsigned fill,
        input int unsigned wash,
        input int unsigned drain,
        input int unsigned rinse,
        input int unsigned spin
    );
        int unsigned d;
        d = 32'd0;
        unique case (ph)
            PH_FILL_1,
            PH_FILL_2:  d = fill;
            PH_WASH:    d = quick_dur(wash, q);
            PH_DRAIN_1,
            PH_DRAIN_2: d = drain;
            PH_RINSE:   d = quick_dur(rinse, q);
            PH_SPIN:    d = quick_dur(spin, q);
            default:    d = 32'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wash_cycle_timer_tick_prescaler.sv
// Free-running tick prescaler with synchronous clear and enable;
// tick marks the enabled cycle at terminal count.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW =
        (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/wash_cycle_timer.sv
// Per-phase duration timer: loads a phase duration on restart,
// counts prescaled ticks with door-hold pause, raises one done flag.
module wash_cycle_timer
    import washer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned FILL_T   = 30,
    parameter int unsigned WASH_T   = 120,
    parameter int unsigned DRAIN_T  = 20,
    parameter int unsigned RINSE_T  = 60,
    parameter int unsigned SPIN_T   = 90
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             R,
    input  logic [2:0]       phase,
    input  logic             hold,
    input  logic             quick,
    output logic             Tf,
    output logic             Tw,
    output logic             Td,
    output logic             Tr,
    output logic             Ts,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    localparam longint unsigned CNT_MAX =
        (64'd1 << CNT_W) - 64'd1;

    generate
        if (TICK_DIV < 2) begin : g_div_chk
            $error("TICK_DIV must be at least 2");
        end
        if (FILL_T > CNT_MAX || WASH_T > CNT_MAX ||
            DRAIN_T > CNT_MAX || RINSE_T > CNT_MAX ||
            SPIN_T > CNT_MAX) begin : g_dur_chk
            $error("phase duration exceeds CNT_W");
        end
    endgenerate

    tstate_t          state, state_nx;
    logic [CNT_W-1:0] rem_q, rem_nx;
    logic [2:0]       ph_q, ph_nx;
    tflags_t          flags_q, flags_nx;
    logic [CNT_W-1:0] load_val;
    logic             presc_en;
    logic             tick;

    assign load_val = CNT_W'(phase_duration(
        phase, quick, FILL_T, WASH_T,
        DRAIN_T, RINSE_T, SPIN_T));

    // Restart owns the prescaler; PAUSE with hold released counts too,
    // so a pause shifts completion by exactly the held cycles.
    assign presc_en = !R && !hold &&
        ((state == T_RUN) || (state == T_PAUSE));

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .reset(reset),
        .clr  (R),
        .en   (presc_en),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= T_IDLE;
            rem_q   <= '0;
            ph_q    <= PH_IDLE;
            flags_q <= '0;
        end else begin
            state   <= state_nx;
            rem_q   <= rem_nx;
            ph_q    <= ph_nx;
            flags_q <= flags_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem_q;
        ph_nx    = ph_q;
        flags_nx = flags_q;
        if (R) begin
            state_nx = T_ARM;
            rem_nx   = '0;
            flags_nx = '0;
        end else begin
            unique case (state)
                T_IDLE: ;
                T_ARM: begin
                    ph_nx = phase;
                    if (phase == PH_IDLE) begin
                        state_nx = T_IDLE;
                    end else begin
                        rem_nx   = load_val;
                        state_nx = (load_val == '0) ?
                            T_DONE : T_RUN;
                    end
                end
                T_RUN, T_PAUSE: begin
                    if (hold) begin
                        state_nx = T_PAUSE;
                    end else begin
                        state_nx = T_RUN;
                        if (tick) begin
                            rem_nx = rem_q - CNT_W'(1);
                            if (rem_q == CNT_W'(1)) begin
                                state_nx = T_DONE;
                            end
                        end
                    end
                end
                T_DONE: flags_nx = phase_flags(ph_q);
                default: state_nx = T_IDLE;
            endcase
        end
    end

    assign Tf        = flags_q.tf;
    assign Tw        = flags_q.tw;
    assign Td        = flags_q.td;
    assign Tr        = flags_q.tr;
    assign Ts        = flags_q.ts;
    assign remaining = rem_q;
    assign busy      = (state == T_ARM) ||
                       (state == T_RUN) ||
                       (state == T_PAUSE);

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Directed bench for wash_cycle_timer with TICK_DIV=4 and short
// durations (fill 3, wash 6, drain 2, rinse 4, spin 5).
module tb_wash_cycle_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       R;
  logic [2:0] phase;
  logic       hold;
  logic       quick;
  logic       Tf, Tw, Td, Tr, Ts;
  logic       busy;
  logic [7:0] remaining;
  logic [4:0] fl;

  int errors = 0;
  int checks = 0;

  int unsigned seq_dur [7] = '{3, 6, 2, 3, 4, 2, 5};
  logic [4:0]  seq_fl  [7] = '{5'b00001, 5'b00010, 5'b00100,
                               5'b00001, 5'b01000, 5'b00100,
                               5'b10000};

  always #5 clk = ~clk;

  assign fl = {Ts, Tr, Td, Tw, Tf};

  wash_cycle_timer #(
    .TICK_DIV(4),
    .CNT_W   (8),
    .FILL_T  (3),
    .WASH_T  (6),
    .DRAIN_T (2),
    .RINSE_T (4),
    .SPIN_T  (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .R        (R),
    .phase    (phase),
    .hold     (hold),
    .quick    (quick),
    .Tf       (Tf),
    .Tw       (Tw),
    .Td       (Td),
    .Tr       (Tr),
    .Ts       (Ts),
    .busy     (busy),
    .remaining(remaining)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_r(input logic [2:0] ph, input logic q);
    R = 1'b1;
    step();
    R = 1'b0;
    phase = ph;
    quick = q;
    step();
  endtask

  task automatic wait_flag(input int n0, output int n);
    n = n0;
    while (fl == 5'b0 && n < n0 + 400) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    R = 1'b0;
    hold = 1'b0;
    quick = 1'b0;
    phase = 3'd0;
    repeat (3) step();
    checks++;
    if ({fl, busy, remaining} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {fl, busy, remaining});
    end
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      hold = 1'($urandom_range(0, 1));
      step();
      checks++;
      if ({fl, busy, remaining} !== 14'd0) begin
        errors++;
        $display("FAIL idle_hold_%0d: got %b expected 0",
                 i, {fl, busy, remaining});
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_basic_fill();
    int n;
    pulse_r(3'd1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_busy: got %b expected 1", busy);
    end
    checks++;
    if (remaining !== 8'd3) begin
      errors++;
      $display("FAIL fill_load: got %0d expected 3", remaining);
    end
    wait_flag(1, n);
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL fill_latency: got %0d expected 14", n);
    end
    checks++;
    if (fl !== 5'b00001) begin
      errors++;
      $display("FAIL fill_flag: got %b expected 00001", fl);
    end
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    checks++;
    if ({fl, busy, remaining} !== {5'b00001, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL fill_level: got %b expected %b",
               {fl, busy, remaining},
               {5'b00001, 1'b0, 8'd0});
    end
    R = 1'b1;
    step();
    R = 1'b0;
    phase = 3'd0;
    checks++;
    if (fl !== 5'b0) begin
      errors++;
      $display("FAIL r_clears_flag: got %b expected 0", fl);
    end
    step();
    checks++;
    if ({busy, remaining} !== 9'd0) begin
      errors++;
      $display("FAIL idle_phase: got %b expected 0",
               {busy, remaining});
    end
  endtask

  task automatic test_full_sequence();
    int n;
    for (int i = 0; i < 7; i++) begin
      pulse_r(3'(i + 1), 1'b0);
      wait_flag(1, n);
      checks++;
      if (n != 2 + 4 * int'(seq_dur[i])) begin
        errors++;
        $display("FAIL seq_latency_%0d: got %0d expected %0d",
                 i + 1, n, 2 + 4 * int'(seq_dur[i]));
      end
      checks++;
      if (fl !== seq_fl[i]) begin
        errors++;
        $display("FAIL seq_flag_%0d: got %b expected %b",
                 i + 1, fl, seq_fl[i]);
      end
    end
  endtask

  task automatic test_pause();
    int n;
    pulse_r(3'd2, 1'b0);
    n = 1;
    repeat (5) begin
      step();
      n++;
    end
    checks++;
    if (remaining !== 8'd5) begin
      errors++;
      $display("FAIL pause_pre: got %0d expected 5", remaining);
    end
    hold = 1'b1;
    repeat (10) begin
      step();
      n++;
    end
    checks++;
    if ({busy, remaining} !== {1'b1, 8'd5}) begin
      errors++;
      $display("FAIL pause_frozen: got %b expected %b",
               {busy, remaining}, {1'b1, 8'd5});
    end
    hold = 1'b0;
    wait_flag(n, n);
    checks++;
    if (n != 36) begin
      errors++;
      $display("FAIL pause_latency: got %0d expected 36", n);
    end
    checks++;
    if (fl !== 5'b00010) begin
      errors++;
      $display("FAIL pause_flag: got %b expected 00010", fl);
    end
  endtask

  task automatic test_quick();
    int n;
    pulse_r(3'd5, 1'b1);
    checks++;
    if (remaining !== 8'd2) begin
      errors++;
      $display("FAIL quick_rinse: got %0d expected 2", remaining);
    end
    pulse_r(3'd2, 1'b1);
    checks++;
    if (remaining !== 8'd3) begin
      errors++;
      $display("FAIL quick_wash: got %0d expected 3", remaining);
    end
    pulse_r(3'd1, 1'b1);
    checks++;
    if (remaining !== 8'd3) begin
      errors++;
      $display("FAIL quick_fill: got %0d expected 3", remaining);
    end
    pulse_r(3'd7, 1'b1);
    checks++;
    if (remaining !== 8'd2) begin
      errors++;
      $display("FAIL quick_spin: got %0d expected 2", remaining);
    end
    step();
    quick = 1'b0;
    step();
    quick = 1'b1;
    wait_flag(3, n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL quick_latency: got %0d expected 10", n);
    end
    checks++;
    if (fl !== 5'b10000) begin
      errors++;
      $display("FAIL quick_flag: got %b expected 10000", fl);
    end
    quick = 1'b0;
  endtask

  task automatic test_r_on_final_tick();
    int n;
    pulse_r(3'd1, 1'b0);
    repeat (11) step();
    checks++;
    if (remaining !== 8'd1) begin
      errors++;
      $display("FAIL coin_pre: got %0d expected 1", remaining);
    end
    R = 1'b1;
    step();
    R = 1'b0;
    phase = 3'd3;
    checks++;
    if ({fl, remaining} !== 13'd0) begin
      errors++;
      $display("FAIL coin_clear: got %b expected 0",
               {fl, remaining});
    end
    step();
    checks++;
    if ({fl, remaining} !== {5'b0, 8'd2}) begin
      errors++;
      $display("FAIL coin_reload: got %b expected %b",
               {fl, remaining}, {5'b0, 8'd2});
    end
    wait_flag(1, n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL coin_latency: got %0d expected 10", n);
    end
    checks++;
    if (fl !== 5'b00100) begin
      errors++;
      $display("FAIL coin_flag: got %b expected 00100", fl);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    pulse_r(3'd2, 1'b0);
    repeat (8) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: got %b expected 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({fl, busy, remaining} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0",
               {fl, busy, remaining});
    end
    repeat (2) step();
    reset = 1'b1;
    repeat (5) step();
    checks++;
    if ({fl, busy, remaining} !== 14'd0) begin
      errors++;
      $display("FAIL no_restart: got %b expected 0",
               {fl, busy, remaining});
    end
    pulse_r(3'd4, 1'b0);
    wait_flag(1, n);
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL rerun_latency: got %0d expected 14", n);
    end
    checks++;
    if (fl !== 5'b00001) begin
      errors++;
      $display("FAIL rerun_flag: got %b expected 00001", fl);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_full_sequence();
    test_pause();
    test_quick();
    test_r_on_final_tick();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
